// File: rtl/washing_machine_plant_model.sv
// Cycle-accurate physical washer model (tank, heater, drum, door latch) driving the controller's sensors.
// Optional define PLANT_FAULT_INJECT_EN adds inlet_fault/drain_fault inputs that block fill or drain flow.
module washing_machine_plant_model #(
    parameter int TICK_DIV       = 5,
    parameter int FILL_RATE      = 4,
    parameter int DRAIN_RATE     = 8,
    parameter int AMBIENT_TEMP   = 20,
    parameter int HEAT_DIV       = 2,
    parameter int COOL_DIV       = 8,
    parameter int HEAT_MIN_LEVEL = 50,
    parameter int SPIN_STEP      = 100,
    parameter int VIB_SPEED      = 1000,
    parameter int LOCK_DELAY     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        water_valve,
    input  logic        drain_pump,
    input  logic        heater,
    input  logic [10:0] drum_motor,
    input  logic        door_lock,
    input  logic        load_unbalanced,
`ifdef PLANT_FAULT_INJECT_EN
    input  logic        inlet_fault,
    input  logic        drain_fault,
`endif
    output logic [9:0]  water_level_sensor,
    output logic [6:0]  temperature_adc_sensor,
    output logic        vibration_sensor,
    output logic        door_locked,
    output logic [10:0] drum_speed,
    output logic        plant_tick
);

    localparam logic [15:0]        TICK_LAST  = 16'(TICK_DIV - 1);
    localparam logic [15:0]        HEAT_LAST  = 16'(HEAT_DIV - 1);
    localparam logic [15:0]        COOL_LAST  = 16'(COOL_DIV - 1);
    localparam logic [15:0]        LOCK_LAST  = 16'(LOCK_DELAY - 1);
    localparam logic signed [11:0] FILL_S     = 12'(FILL_RATE);
    localparam logic signed [11:0] DRAIN_S    = 12'(DRAIN_RATE);
    localparam logic signed [11:0] LEVEL_MAX  = 12'sd1023;
    localparam logic [6:0]         AMBIENT    = 7'(AMBIENT_TEMP);
    localparam logic [6:0]         TEMP_MAX   = 7'd127;
    localparam logic [9:0]         HEAT_MIN   = 10'(HEAT_MIN_LEVEL);
    localparam logic [10:0]        SPIN_W     = 11'(SPIN_STEP);
    localparam logic [10:0]        VIB_W      = 11'(VIB_SPEED);

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKING,
        LOCKED,
        UNLOCKING
    } door_state_t;

    logic [15:0]        prescale_cnt;
    logic [15:0]        heat_cnt;
    logic [15:0]        cool_cnt;
    logic [15:0]        latch_cnt;
    door_state_t        door_state;
    logic               fill_on;
    logic               drain_on;
    logic signed [11:0] level_sum;
    logic [9:0]         level_next;
    logic               heating;
    logic [10:0]        speed_target;
    logic [10:0]        speed_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_cnt <= '0;
        end else if (prescale_cnt == TICK_LAST) begin
            prescale_cnt <= '0;
        end else begin
            prescale_cnt <= prescale_cnt + 16'd1;
        end
    end

    assign plant_tick = (prescale_cnt == TICK_LAST);

`ifdef PLANT_FAULT_INJECT_EN
    assign fill_on  = water_valve && !inlet_fault;
    assign drain_on = drain_pump && !drain_fault;
`else
    assign fill_on  = water_valve;
    assign drain_on = drain_pump;
`endif

    // Fill and drain are summed without priority, then clamped to the tank range.
    always_comb begin
        level_sum = $signed({2'b00, water_level_sensor});
        if (fill_on) begin
            level_sum = level_sum + FILL_S;
        end
        if (drain_on) begin
            level_sum = level_sum - DRAIN_S;
        end
        if (level_sum < 12'sd0) begin
            level_next = '0;
        end else if (level_sum > LEVEL_MAX) begin
            level_next = 10'd1023;
        end else begin
            level_next = level_sum[9:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            water_level_sensor <= '0;
        end else if (plant_tick) begin
            water_level_sensor <= level_next;
        end
    end

    // A dry heater has no effect, so the plant is in cooling mode then.
    assign heating = heater && (water_level_sensor >= HEAT_MIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            temperature_adc_sensor <= AMBIENT;
            heat_cnt               <= '0;
            cool_cnt               <= '0;
        end else if (plant_tick) begin
            if (heating) begin
                cool_cnt <= '0;
                if (heat_cnt == HEAT_LAST) begin
                    heat_cnt <= '0;
                    if (temperature_adc_sensor != TEMP_MAX) begin
                        temperature_adc_sensor <= temperature_adc_sensor + 7'd1;
                    end
                end else begin
                    heat_cnt <= heat_cnt + 16'd1;
                end
            end else begin
                heat_cnt <= '0;
                if (cool_cnt == COOL_LAST) begin
                    cool_cnt <= '0;
                    if (temperature_adc_sensor > AMBIENT) begin
                        temperature_adc_sensor <= temperature_adc_sensor - 7'd1;
                    end else if (temperature_adc_sensor < AMBIENT) begin
                        temperature_adc_sensor <= temperature_adc_sensor + 7'd1;
                    end
                end else begin
                    cool_cnt <= cool_cnt + 16'd1;
                end
            end
        end
    end

    // An unlatched door forces the drum to spin down regardless of the command.
    assign speed_target = door_locked ? drum_motor : 11'd0;

    always_comb begin
        speed_next = speed_target;
        if (drum_speed < speed_target) begin
            if ((speed_target - drum_speed) > SPIN_W) begin
                speed_next = drum_speed + SPIN_W;
            end
        end else if ((drum_speed - speed_target) > SPIN_W) begin
            speed_next = drum_speed - SPIN_W;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drum_speed       <= '0;
            vibration_sensor <= 1'b0;
        end else if (plant_tick) begin
            drum_speed       <= speed_next;
            vibration_sensor <= load_unbalanced && (drum_speed >= VIB_W);
        end
    end

    // Unlocking is only allowed with an empty, stationary drum.
    always_ff @(posedge clk) begin
        if (reset) begin
            door_state  <= UNLOCKED;
            latch_cnt   <= '0;
            door_locked <= 1'b0;
        end else if (plant_tick) begin
            case (door_state)
                UNLOCKED: begin
                    if (door_lock) begin
                        door_state <= LOCKING;
                        latch_cnt  <= '0;
                    end
                end
                LOCKING: begin
                    if (!door_lock) begin
                        door_state <= UNLOCKED;
                        latch_cnt  <= '0;
                    end else if (latch_cnt == LOCK_LAST) begin
                        door_state  <= LOCKED;
                        latch_cnt   <= '0;
                        door_locked <= 1'b1;
                    end else begin
                        latch_cnt <= latch_cnt + 16'd1;
                    end
                end
                LOCKED: begin
                    if (!door_lock && (water_level_sensor == 10'd0) && (drum_speed == 11'd0)) begin
                        door_state <= UNLOCKING;
                        latch_cnt  <= '0;
                    end
                end
                UNLOCKING: begin
                    if (door_lock) begin
                        door_state <= LOCKED;
                        latch_cnt  <= '0;
                    end else if (latch_cnt == LOCK_LAST) begin
                        door_state  <= UNLOCKED;
                        latch_cnt   <= '0;
                        door_locked <= 1'b0;
                    end else begin
                        latch_cnt <= latch_cnt + 16'd1;
                    end
                end
                default: begin
                    door_state  <= UNLOCKED;
                    latch_cnt   <= '0;
                    door_locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_washing_machine_plant_model.sv
// Directed bench for washing_machine_plant_model: table of tick-level phases plus door/spin/reset sequences.
module tb_washing_machine_plant_model;

    localparam int TICK_DIV = 5;

    typedef struct {
        logic        valve;
        logic        drain;
        logic        heat;
        logic [10:0] motor;
        logic        lock;
        logic        unbal;
        int          ticks;
        int          exp_level;
        int          exp_temp;
        int          exp_locked;
        int          exp_speed;
        int          exp_vib;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        water_valve;
    logic        drain_pump;
    logic        heater;
    logic [10:0] drum_motor;
    logic        door_lock;
    logic        load_unbalanced;
    logic [9:0]  water_level_sensor;
    logic [6:0]  temperature_adc_sensor;
    logic        vibration_sensor;
    logic        door_locked;
    logic [10:0] drum_speed;
    logic        plant_tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    washing_machine_plant_model dut (
        .clk                    (clk),
        .reset                  (reset),
        .water_valve            (water_valve),
        .drain_pump             (drain_pump),
        .heater                 (heater),
        .drum_motor             (drum_motor),
        .door_lock              (door_lock),
        .load_unbalanced        (load_unbalanced),
        .water_level_sensor     (water_level_sensor),
        .temperature_adc_sensor (temperature_adc_sensor),
        .vibration_sensor       (vibration_sensor),
        .door_locked            (door_locked),
        .drum_speed             (drum_speed),
        .plant_tick             (plant_tick)
    );

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Waits for n plant ticks, then one more falling edge so the last update is visible.
    task automatic run_ticks(input int n);
        int seen  = 0;
        int guard = 0;
        while (seen < n && guard < (n + 2) * TICK_DIV) begin
            @(negedge clk);
            guard++;
            if (plant_tick) seen++;
        end
        @(negedge clk);
        if (seen != n) check_output("tick_timeout", seen, n);
    endtask

    task automatic apply_stimulus(input vec_t v);
        water_valve     = v.valve;
        drain_pump      = v.drain;
        heater          = v.heat;
        drum_motor      = v.motor;
        door_lock       = v.lock;
        load_unbalanced = v.unbal;
    endtask

    task automatic check_all(input string tag, input int lvl, input int tmp, input int lck,
                             input int spd, input int vib);
        check_output({tag, "_level"},  int'(water_level_sensor),     lvl);
        check_output({tag, "_temp"},   int'(temperature_adc_sensor), tmp);
        check_output({tag, "_locked"}, int'(door_locked),            lck);
        check_output({tag, "_speed"},  int'(drum_speed),             spd);
        check_output({tag, "_vib"},    int'(vibration_sensor),       vib);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[14];
        int   tick_seen;

        // Each row holds its inputs for the given number of ticks; expectations follow on from the previous row.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 11'd0,    1'b0, 1'b0,  5,  20, 20, 0, 0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 11'd0,    1'b0, 1'b0, 20, 100, 20, 0, 0, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 11'd0,    1'b0, 1'b0, 20, 100, 30, 0, 0, 0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 11'd0,    1'b0, 1'b0, 80, 100, 20, 0, 0, 0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 11'd0,    1'b0, 1'b0, 11,  12, 20, 0, 0, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 11'd0,    1'b0, 1'b0, 20,  12, 20, 0, 0, 0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 11'd0,    1'b0, 1'b0,  9,  48, 20, 0, 0, 0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 11'd0,    1'b0, 1'b0,  4,  48, 20, 0, 0, 0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 11'd0,    1'b0, 1'b0,  2,  56, 20, 0, 0, 0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 11'd0,    1'b0, 1'b0,  1,  56, 21, 0, 0, 0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 11'd0,    1'b0, 1'b0,  1,  52, 21, 0, 0, 0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 11'd0,    1'b0, 1'b0,  6,   4, 21, 0, 0, 0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 11'd0,    1'b0, 1'b0,  1,   0, 20, 0, 0, 0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 11'd1400, 1'b0, 1'b1,  3,   0, 20, 0, 0, 0};

        reset           = 1'b1;
        water_valve     = 1'b0;
        drain_pump      = 1'b0;
        heater          = 1'b0;
        drum_motor      = 11'd0;
        door_lock       = 1'b0;
        load_unbalanced = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset", 0, 20, 0, 0, 0);
        check_output("reset_tick", int'(plant_tick), 0);

        // 50 clocks of fill from a freshly cleared prescaler is exactly 10 ticks.
        reset       = 1'b0;
        water_valve = 1'b1;
        tick_seen   = 0;
        repeat (50) begin
            @(negedge clk);
            if (plant_tick) tick_seen++;
        end
        water_valve = 1'b0;
        check_output("fill_tick_count", tick_seen, 10);
        check_output("fill_level", int'(water_level_sensor), 40);

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i]);
            run_ticks(vecs[i].ticks);
            check_all($sformatf("row%0d", i), vecs[i].exp_level, vecs[i].exp_temp,
                      vecs[i].exp_locked, vecs[i].exp_speed, vecs[i].exp_vib);
        end

        drum_motor      = 11'd0;
        load_unbalanced = 1'b0;
        door_lock       = 1'b1;
        run_ticks(2);
        check_output("lock_abort_pre", int'(door_locked), 0);
        door_lock = 1'b0;
        run_ticks(1);
        door_lock = 1'b1;
        run_ticks(3);
        check_output("lock_delay_early", int'(door_locked), 0);
        run_ticks(1);
        check_output("lock_engaged", int'(door_locked), 1);

        drum_motor      = 11'd1400;
        load_unbalanced = 1'b1;
        run_ticks(10);
        check_output("spin_1000_speed", int'(drum_speed), 1000);
        check_output("spin_1000_vib", int'(vibration_sensor), 0);
        run_ticks(1);
        check_output("spin_1100_speed", int'(drum_speed), 1100);
        check_output("spin_1100_vib", int'(vibration_sensor), 1);
        run_ticks(3);
        check_output("spin_full_speed", int'(drum_speed), 1400);
        run_ticks(1);
        check_output("spin_hold_speed", int'(drum_speed), 1400);
        drum_motor = 11'd1350;
        run_ticks(1);
        check_output("spin_small_step", int'(drum_speed), 1350);

        water_valve = 1'b1;
        run_ticks(10);
        water_valve = 1'b0;
        door_lock   = 1'b0;
        run_ticks(5);
        check_all("guard_full", 40, 20, 1, 1350, 1);

        drum_motor      = 11'd0;
        load_unbalanced = 1'b0;
        drain_pump      = 1'b1;
        run_ticks(13);
        check_output("spindown_speed", int'(drum_speed), 50);
        run_ticks(1);
        check_all("guard_empty", 0, 20, 1, 0, 0);
        run_ticks(3);
        check_output("unlock_delay_early", int'(door_locked), 1);
        run_ticks(1);
        check_output("unlock_released", int'(door_locked), 0);
        drain_pump = 1'b0;

        water_valve = 1'b1;
        run_ticks(255);
        check_output("clamp_1020", int'(water_level_sensor), 1020);
        run_ticks(1);
        check_output("clamp_1023", int'(water_level_sensor), 1023);
        water_valve = 1'b0;
        drain_pump  = 1'b1;
        run_ticks(1);
        check_output("drain_from_max", int'(water_level_sensor), 1015);
        drain_pump = 1'b0;

        reset = 1'b1;
        @(negedge clk);
        check_output("reset_full_level", int'(water_level_sensor), 0);
        reset = 1'b0;

        water_valve = 1'b1;
        run_ticks(50);
        water_valve = 1'b0;
        heater      = 1'b1;
        run_ticks(30);
        check_output("prefill_level", int'(water_level_sensor), 200);
        check_output("prefill_temp", int'(temperature_adc_sensor), 35);
        water_valve = 1'b1;
        door_lock   = 1'b1;
        run_ticks(2);
        check_output("midfill_level", int'(water_level_sensor), 208);
        check_output("midfill_temp", int'(temperature_adc_sensor), 36);
        reset = 1'b1;
        @(negedge clk);
        check_all("midreset", 0, 20, 0, 0, 0);
        check_output("midreset_tick", int'(plant_tick), 0);
        reset       = 1'b0;
        water_valve = 1'b0;
        heater      = 1'b0;
        door_lock   = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
